// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out bundle for uart_rx_word_packer.
// master = byte source and word consumer side, slave = the packer.
interface uart_rx_word_packer_if #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 4
);
    logic [7:0]                      rx_byte;
    logic                            rx_en;
    logic                            clear;
    logic [8*WORD_BYTES-1:0]         word_data;
    logic [$clog2(WORD_BYTES):0]     word_nbytes;
    logic                            word_valid;
    logic                            word_ready;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;
    logic                            overflow;

    modport master (
        output rx_byte, rx_en, clear, word_ready,
        input  word_data, word_nbytes, word_valid, fifo_count, overflow
    );

    modport slave (
        input  rx_byte, rx_en, clear, word_ready,
        output word_data, word_nbytes, word_valid, fifo_count, overflow
    );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs UART bytes little-endian into words and queues them in a show-ahead FIFO.
// Optional partial-word idle flush is enabled with `define UART_PACK_TIMEOUT_EN.

module uart_pack_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (wr)  q <= din;
    end
endmodule

module uart_rx_word_packer #(
    parameter int WORD_BYTES  = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_word_packer_if.slave  bus
);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int NW = $clog2(WORD_BYTES) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    if (WORD_BYTES < 2 || WORD_BYTES > 8) begin : g_bad_wb
        $error("WORD_BYTES must be 2..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("TIMEOUT_CYC must be >= 1");
    end

    typedef struct packed {
        logic [NW-1:0]                nbytes;
        logic [WORD_BYTES-1:0][7:0]   data;
    } word_t;

    logic [IW-1:0]              byte_idx;
    logic [WORD_BYTES-1:0][7:0] lane_q;
    logic                       last_byte;
    logic                       flush;
    logic                       push;
    logic                       asm_clr;
    word_t                      push_word;

    assign last_byte = bus.rx_en && (byte_idx == IW'(WORD_BYTES - 1));
    assign push      = !bus.clear && (last_byte || flush);
    assign asm_clr   = bus.clear || last_byte || flush;

    // The completing byte bypasses its lane so the word is pushed on the strobe edge.
    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
        uart_pack_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (asm_clr),
            .wr    (bus.rx_en && byte_idx == IW'(i)),
            .din   (bus.rx_byte),
            .q     (lane_q[i])
        );
        assign push_word.data[i] = (bus.rx_en && byte_idx == IW'(i)) ? bus.rx_byte : lane_q[i];
    end
    assign push_word.nbytes = flush ? NW'(byte_idx) : NW'(WORD_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       byte_idx <= '0;
        else if (asm_clr)                 byte_idx <= '0;
        else if (bus.rx_en)               byte_idx <= byte_idx + IW'(1);
    end

`ifdef UART_PACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt;
    logic          idle;

    // A strobe always restarts the count, so rx_en beats a coincident timeout.
    assign idle  = (byte_idx != '0) && !bus.rx_en;
    assign flush = idle && (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          idle_cnt <= '0;
        else if (bus.clear || !idle || flush) idle_cnt <= '0;
        else                                 idle_cnt <= idle_cnt + TW'(1);
    end
`else
    assign flush = 1'b0;
`endif

    word_t         mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf_q;
    logic          pop, full, push_ok;

    assign full    = (count == CW'(FIFO_DEPTH));
    pop_gate: assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == '0));
    assign pop     = bus.word_valid && bus.word_ready && !bus.clear;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok)         wr_ptr <= wr_ptr + PW'(1);
            if (pop)             rd_ptr <= rd_ptr + PW'(1);
            if (push && !push_ok) ovf_q <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    // Head is gated so an empty FIFO presents all-zero outputs, as after reset.
    assign bus.word_valid  = (count != '0);
    assign bus.word_data   = bus.word_valid ? mem[rd_ptr].data   : '0;
    assign bus.word_nbytes = bus.word_valid ? mem[rd_ptr].nbytes : '0;
    assign bus.fifo_count  = count;
    assign bus.overflow    = ovf_q;
endmodule
